wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order write-back stage and the
//  long-latency unit (MULT/DIV/CP0 result path). Pipeline writes normally win. Long-unit results
//  wait in a small pending FIFO. A starvation counter forces a one-cycle WB stall so the oldest
//  pending result can retire. It also reports pending destinations to the hazard unit.
// PARAMETERS
//  DEPTH     2   pending FIFO entries (power of 2, >=2)
//  MAX_WAIT  4   cycles a non-empty FIFO head may wait before WB is stalled (>=1)
//  AW        5   register address width
//  DW        32  register data width
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  pipe_wena    in   1   WB stage write enable (from write-back mux stage)
//  pipe_waddr   in   AW  WB stage destination
//  pipe_wdata   in   DW  WB stage data
//  lu_valid     in   1   long unit result valid
//  lu_waddr     in   AW  long unit destination
//  lu_wdata     in   DW  long unit data
//  lu_ready     out  1   FIFO can accept (= !full)
//  pipe_stall   out  1   WB write deferred this cycle; upstream must hold WB inputs
//  rf_wena      out  1   regfile write enable
//  rf_waddr     out  AW  regfile write address
//  rf_wdata     out  DW  regfile write data
//  q_addr       in   AW  hazard-unit query address
//  q_hit        out  1   some valid FIFO entry targets q_addr (0 when q_addr==0)
//  pend_cnt     out  log2(DEPTH)+1  number of valid FIFO entries
// BEHAVIOUR
//  - Reset (rst_n low, async): FIFO emptied, pointers and wait_cnt=0. While rst_n is low,
//    rf_wena=0, pipe_stall=0, q_hit=0 and pend_cnt=0; lu_ready=1 after release.
//  - Reset asserted mid-operation discards all pending entries; no write is issued.
//  - pw = pipe_wena && pipe_waddr!=0. A write to $0 is treated as no request.
//  - Accept: lu_valid && lu_ready pushes {lu_waddr,lu_wdata} at the clock edge. lu_waddr==0 is
//    accepted (handshake completes) but not stored.
//  - lu_ready depends on full only. When full, no push occurs even if a pop happens that cycle.
//  - No same-cycle bypass: a long-unit result reaches rf_w* at the earliest one cycle after
//    acceptance.
//  - Combinational grant, in priority order:
//     1) starve = !empty && wait_cnt>=MAX_WAIT: rf_w* = FIFO head, pop, pipe_stall = pw.
//     2) pw: rf_w* = pipe inputs, pipe_stall=0.
//     3) !empty: rf_w* = FIFO head, pop.
//     4) otherwise rf_wena=0. rf_waddr/rf_wdata = pipe inputs (don't-care).
//  - pipe_stall is never asserted when pw=0.
//  - wait_cnt cleared on a pop or when the FIFO is empty. Otherwise it increments, saturating at
//    MAX_WAIT. A push does not affect it.
//  - Simultaneous push and pop when not full: pend_cnt unchanged, order preserved (strict FIFO).
//  - Pointers wrap modulo DEPTH. The extra count bit distinguishes full from empty.
//  - Ordering is the hazard unit's responsibility, using q_hit: the arbiter never reorders two
//    writes to the same address within the FIFO. Pipe vs FIFO ordering to the same register is
//    also left to the hazard unit.
//  - Latency: pipe write to rf_w* is 0 cycles (combinational). FIFO entry retires no later than
//    (entries ahead + 1) * (MAX_WAIT + 1) cycles after acceptance.
// STRUCTURE
//  - Shared package mips_pkg: AW, DW, REG_ZERO (5'd0), and a wb_req_t struct {wena, waddr, wdata}.
//  - Sub-module wb_pend_fifo: DEPTH-entry FIFO with push/pop/full/empty/count and a per-entry
//    address-compare vector for q_hit.
//  - Top level: grant mux, starvation counter, q_hit OR-reduce.
// TESTING
//  1) Reset, then lu_valid=1 with waddr=8, wdata=0x1234 and pw=0 -> next cycle rf_wena=1,
//     rf_waddr=8, rf_wdata=0x1234; pend_cnt 1->0.
//  2) pw=1 every cycle (waddr=3) with one FIFO entry (waddr=9) -> pipe wins 4 cycles; in cycle 5
//     pipe_stall=1 and rf_waddr=9; cycle 6 writes waddr=3 (held input).
//  3) Push 2 entries with pw=1 held -> lu_ready=0 and pend_cnt=2; a third lu_valid is not
//     accepted until a pop; entries retire in push order.
//  4) lu_waddr=0 pushed -> lu_ready handshake completes, pend_cnt stays 0, no rf write.
//     pipe_waddr=0 with pipe_wena=1 -> FIFO head granted, pipe_stall=0.
//  5) FIFO holds waddr=17: q_addr=17 -> q_hit=1; q_addr=0 -> q_hit=0; after the pop, q_hit=0.
//  6) Assert rst_n low mid-stream with 2 entries pending -> rf_wena=0 immediately, pend_cnt=0;
//     after release no stale write appears.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared register-file definitions for the write-back datapath.
package mips_pkg;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic          wena;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending-result FIFO for long-unit write-backs; wena doubles as the per-entry valid bit
// so the hazard compare vector needs no pointer arithmetic.
module wb_pend_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [AW-1:0]              push_addr_i,
  input  logic [DW-1:0]              push_data_i,
  input  logic [AW-1:0]              q_addr_i,
  output wb_req_t                    head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [DEPTH-1:0]           hit_vec_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_req_t             mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even if a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    hit_vec_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit_vec_o[i] = mem_q[i].wena && (mem_q[i].waddr == q_addr_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (do_pop) begin
        mem_q[rd_ptr_q].wena <= 1'b0;
        rd_ptr_q             <= rd_ptr_q + PtrW'(1);
      end
      if (do_push) begin
        mem_q[wr_ptr_q] <= '{wena: 1'b1, waddr: push_addr_i, wdata: push_data_i};
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and the long unit,
// with a starvation counter that briefly stalls WB so pending results always drain.
module wb_port_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pipe_wena_i,
  input  logic [AW-1:0]          pipe_waddr_i,
  input  logic [DW-1:0]          pipe_wdata_i,
  input  logic                   lu_valid_i,
  input  logic [AW-1:0]          lu_waddr_i,
  input  logic [DW-1:0]          lu_wdata_i,
  output logic                   lu_ready_o,
  output logic                   pipe_stall_o,
  output logic                   rf_wena_o,
  output logic [AW-1:0]          rf_waddr_o,
  output logic [DW-1:0]          rf_wdata_o,
  input  logic [AW-1:0]          q_addr_i,
  output logic                   q_hit_o,
  output logic [$clog2(DEPTH):0] pend_cnt_o
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  wb_req_t            head;
  logic               full, empty, pw, starve, push, pop;
  logic               grant_wena, grant_stall;
  logic [DEPTH-1:0]   hit_vec;
  logic [WaitW-1:0]   wait_q, wait_d;

  // Address 0 results complete the handshake but are never stored.
  assign push       = lu_valid_i && !full && (lu_waddr_i != REG_ZERO);
  assign lu_ready_o = !full;

  wb_pend_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .push_addr_i (lu_waddr_i),
    .push_data_i (lu_wdata_i),
    .q_addr_i    (q_addr_i),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (pend_cnt_o),
    .hit_vec_o   (hit_vec)
  );

  assign pw     = pipe_wena_i && (pipe_waddr_i != REG_ZERO);
  assign starve = !empty && (wait_q >= WaitW'(MAX_WAIT));

  always_comb begin
    grant_wena  = 1'b0;
    grant_stall = 1'b0;
    pop         = 1'b0;
    rf_waddr_o  = pipe_waddr_i;
    rf_wdata_o  = pipe_wdata_i;
    if (starve) begin
      grant_wena  = 1'b1;
      grant_stall = pw;
      pop         = 1'b1;
      rf_waddr_o  = head.waddr;
      rf_wdata_o  = head.wdata;
    end else if (pw) begin
      grant_wena  = 1'b1;
    end else if (!empty) begin
      grant_wena  = 1'b1;
      pop         = 1'b1;
      rf_waddr_o  = head.waddr;
      rf_wdata_o  = head.wdata;
    end
  end

  // Reset must silence the write port immediately, not just at the next edge.
  assign rf_wena_o    = rst_n && grant_wena;
  assign pipe_stall_o = rst_n && grant_stall;
  assign q_hit_o      = (q_addr_i != REG_ZERO) && (|hit_vec);

  always_comb begin
    wait_d = wait_q;
    if (pop || empty) begin
      wait_d = '0;
    end else if (wait_q < WaitW'(MAX_WAIT)) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

endmodule
